// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, registers fetched words, offers them
// over valid/ready, and selects the next PC (sequential/branch/jump/call/return)
// using an internal return-address stack.
module instr_fetch_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int unsigned STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] imemAddr,
    input  logic [15:0] imemData,
    output logic [15:0] instrOut,
    output logic [15:0] pcOut,
    output logic        instrValid,
    input  logic        instrReady,
    input  logic        done,
    input  logic        redirect,
    input  logic [1:0]  redirectKind,
    input  logic [15:0] redirectTarget,
    output logic        stackOverflow,
    output logic        stackUnderflow,
    output logic [3:0]  stackCount
);

    localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned CW = $clog2(STACK_DEPTH + 1);

    localparam logic [1:0] KIND_BRANCH = 2'b00;
    localparam logic [1:0] KIND_JUMP   = 2'b01;
    localparam logic [1:0] KIND_CALL   = 2'b10;
    localparam logic [1:0] KIND_RETURN = 2'b11;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_OFFER = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [15:0]   pc;
    logic [15:0]   stack_mem [STACK_DEPTH];
    logic [CW-1:0] cnt;

    logic          fetch_c;
    logic          accept_c;
    logic          exec_done_c;
    logic [15:0]   ret_c;
    logic [15:0]   pc_nx_c;
    logic          push_c;
    logic          pop_c;
    logic          ovf_set_c;
    logic          unf_set_c;

    assign imemAddr   = pc;
    assign stackCount = 4'(cnt);
    assign ret_c      = pcOut + 16'd1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and per-state action strobes
    always_comb begin
        state_nx    = state;
        fetch_c     = 1'b0;
        accept_c    = 1'b0;
        exec_done_c = 1'b0;
        case (state)
            S_FETCH: begin
                fetch_c  = 1'b1;
                state_nx = S_OFFER;
            end
            S_OFFER: begin
                if (instrReady) begin
                    accept_c = 1'b1;
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                if (done) begin
                    exec_done_c = 1'b1;
                    state_nx    = S_FETCH;
                end
            end
            default: state_nx = S_FETCH;
        endcase
    end

    // Next-PC selection and stack operation decode
    always_comb begin
        pc_nx_c   = ret_c;
        push_c    = 1'b0;
        pop_c     = 1'b0;
        ovf_set_c = 1'b0;
        unf_set_c = 1'b0;
        if (redirect) begin
            case (redirectKind)
                KIND_BRANCH, KIND_JUMP: pc_nx_c = redirectTarget;
                KIND_CALL: begin
                    pc_nx_c = redirectTarget;
                    if (cnt == CW'(STACK_DEPTH)) begin
                        ovf_set_c = 1'b1;
                    end else begin
                        push_c = 1'b1;
                    end
                end
                KIND_RETURN: begin
                    if (cnt == '0) begin
                        unf_set_c = 1'b1;
                    end else begin
                        pop_c   = 1'b1;
                        pc_nx_c = stack_mem[IW'(cnt - CW'(1))];
                    end
                end
                default: pc_nx_c = ret_c;
            endcase
        end
    end

    // PC and instruction/handshake registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= RESET_PC;
            instrOut   <= '0;
            pcOut      <= '0;
            instrValid <= 1'b0;
        end else begin
            if (fetch_c) begin
                instrOut   <= imemData;
                pcOut      <= pc;
                instrValid <= 1'b1;
            end
            if (accept_c) begin
                instrValid <= 1'b0;
            end
            if (exec_done_c) begin
                pc <= pc_nx_c;
            end
        end
    end

    // Stack depth counter and sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt            <= '0;
            stackOverflow  <= 1'b0;
            stackUnderflow <= 1'b0;
        end else if (exec_done_c) begin
            if (push_c) begin
                cnt <= cnt + CW'(1);
            end
            if (pop_c) begin
                cnt <= cnt - CW'(1);
            end
            if (ovf_set_c) begin
                stackOverflow <= 1'b1;
            end
            if (unf_set_c) begin
                stackUnderflow <= 1'b1;
            end
        end
    end

    // Return-address storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (!reset && exec_done_c && push_c) begin
            stack_mem[IW'(cnt)] <= ret_c;
        end
    end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Testbench for instr_fetch_sequencer: directed table, multi-cycle corner
// sequences, and randomized instruction streams checked against a queue model.
module tb_instr_fetch_sequencer;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] imemAddr;
    logic [15:0] imemData;
    logic [15:0] instrOut;
    logic [15:0] pcOut;
    logic        instrValid;
    logic        instrReady;
    logic        done;
    logic        redirect;
    logic [1:0]  redirectKind;
    logic [15:0] redirectTarget;
    logic        stackOverflow;
    logic        stackUnderflow;
    logic [3:0]  stackCount;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [15:0] m_pc;
    logic [15:0] m_stk[$];
    logic        m_ovf;
    logic        m_unf;

    instr_fetch_sequencer #(.RESET_PC(16'h0000), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imemAddr(imemAddr), .imemData(imemData),
        .instrOut(instrOut), .pcOut(pcOut), .instrValid(instrValid),
        .instrReady(instrReady), .done(done),
        .redirect(redirect), .redirectKind(redirectKind),
        .redirectTarget(redirectTarget),
        .stackOverflow(stackOverflow), .stackUnderflow(stackUnderflow),
        .stackCount(stackCount)
    );

    always #5 clk = ~clk;

    // instruction memory contents: address-derived word, mem[0] = 16'h3001
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3001;
    endfunction

    assign imemData = mem_word(imemAddr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = 16'h0000;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // apply completion rules to the model: return address is current PC + 1
    task automatic model_done(input logic redir, input logic [1:0] kind, input logic [15:0] tgt);
        logic [15:0] ret;
        ret = m_pc + 16'd1;
        if (!redir) begin
            m_pc = ret;
        end else if (kind == 2'b10) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(ret);
            else m_ovf = 1'b1;
            m_pc = tgt;
        end else if (kind == 2'b11) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
                m_unf = 1'b1;
                m_pc  = ret;
            end
        end else begin
            m_pc = tgt;
        end
    endtask

    task automatic chk_offer(input string tag);
        chk({tag, "_valid"}, 32'(instrValid), 32'd1);
        chk({tag, "_pc"}, 32'(pcOut), 32'(m_pc));
        chk({tag, "_instr"}, 32'(instrOut), 32'(mem_word(m_pc)));
    endtask

    // one instruction from OFFER: stall, accept, execute, complete, refetch
    task automatic run_instr(input logic redir, input logic [1:0] kind, input logic [15:0] tgt,
                             input int stall, input int exec_wait);
        logic [15:0] held_pc;
        logic [15:0] held_instr;
        chk_offer("offer");
        held_pc    = pcOut;
        held_instr = instrOut;
        instrReady = 1'b0;
        for (int i = 0; i < stall; i++) begin
            done = 1'b1;
            step();
            chk("stall_valid", 32'(instrValid), 32'd1);
            chk("stall_pc", 32'(pcOut), 32'(held_pc));
            chk("stall_instr", 32'(instrOut), 32'(held_instr));
        end
        done       = 1'b0;
        instrReady = 1'b1;
        step();
        instrReady = 1'b0;
        chk("accept_valid", 32'(instrValid), 32'd0);
        for (int i = 0; i < exec_wait; i++) step();
        done           = 1'b1;
        redirect       = redir;
        redirectKind   = kind;
        redirectTarget = tgt;
        step();
        done     = 1'b0;
        redirect = 1'b0;
        model_done(redir, kind, tgt);
        chk("lat1_valid", 32'(instrValid), 32'd0);
        chk("imem_addr", 32'(imemAddr), 32'(m_pc));
        step();
        chk("lat2_valid", 32'(instrValid), 32'd1);
        chk("stack_count", 32'(stackCount), 32'(m_stk.size()));
        chk("ovf_flag", 32'(stackOverflow), 32'(m_ovf));
        chk("unf_flag", 32'(stackUnderflow), 32'(m_unf));
    endtask

    task automatic do_reset_checks(input string tag);
        chk({tag, "_valid"}, 32'(instrValid), 32'd0);
        chk({tag, "_instr"}, 32'(instrOut), 32'd0);
        chk({tag, "_pcout"}, 32'(pcOut), 32'd0);
        chk({tag, "_imem"}, 32'(imemAddr), 32'h0000);
        chk({tag, "_count"}, 32'(stackCount), 32'd0);
        chk({tag, "_ovf"}, 32'(stackOverflow), 32'd0);
        chk({tag, "_unf"}, 32'(stackUnderflow), 32'd0);
    endtask

    typedef struct {
        logic        redir;
        logic [1:0]  kind;
        logic [15:0] target;
        int          stall;
        logic [15:0] exp_pc;
        int          exp_cnt;
        logic        exp_ovf;
        logic        exp_unf;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // directed vectors from pc 0 after reset, expected values hand-derived
        vecs[0] = '{1'b0, 2'b00, 16'h0000, 0, 16'h0001, 0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 2'b00, 16'h0000, 0, 16'h0002, 0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 2'b00, 16'h0000, 5, 16'h0003, 0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 2'b01, 16'h0006, 0, 16'h0006, 0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 2'b10, 16'h0004, 0, 16'h0004, 1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 2'b00, 16'h0020, 1, 16'h0020, 1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 2'b11, 16'hBEEF, 0, 16'h0007, 0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 2'b01, 16'hFFFF, 0, 16'hFFFF, 0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 2'b00, 16'h0000, 0, 16'h0000, 0, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 2'b11, 16'h1234, 2, 16'h0001, 0, 1'b0, 1'b1};

        reset = 1'b1; instrReady = 1'b0; done = 1'b0;
        redirect = 1'b0; redirectKind = 2'b00; redirectTarget = 16'h0000;
        model_reset();
        repeat (3) step();
        do_reset_checks("rst");

        // first edge after release captures mem[RESET_PC]
        reset = 1'b0;
        step();
        chk("first_valid", 32'(instrValid), 32'd1);
        chk("first_instr", 32'(instrOut), 32'h3001);
        chk("first_pc", 32'(pcOut), 32'h0000);

        foreach (vecs[i]) begin
            run_instr(vecs[i].redir, vecs[i].kind, vecs[i].target, vecs[i].stall, 0);
            chk("tbl_pc", 32'(pcOut), 32'(vecs[i].exp_pc));
            chk("tbl_cnt", 32'(stackCount), 32'(vecs[i].exp_cnt));
            chk("tbl_ovf", 32'(stackOverflow), 32'(vecs[i].exp_ovf));
            chk("tbl_unf", 32'(stackUnderflow), 32'(vecs[i].exp_unf));
        end

        // reset while offering clears handshake, pc and sticky flags
        chk("pre_rst_unf", 32'(stackUnderflow), 32'd1);
        reset = 1'b1;
        step();
        do_reset_checks("rst_offer");
        reset = 1'b0;
        model_reset();
        step();
        chk_offer("post_rst");

        // nine nested calls overflow an 8-deep stack
        for (int i = 0; i < 9; i++) begin
            run_instr(1'b1, 2'b10, 16'(16'h1000 + 16 * i), 0, 0);
        end
        chk("nest_ovf", 32'(stackOverflow), 32'd1);
        chk("nest_cnt", 32'(stackCount), 32'd8);
        chk("nest_pc", 32'(pcOut), 32'h1080);
        // nine returns: eight in LIFO order then underflow fall-through
        for (int i = 0; i < 8; i++) run_instr(1'b1, 2'b11, 16'h0000, 0, 0);
        chk("ret8_pc", 32'(pcOut), 32'h0001);
        chk("ret8_unf", 32'(stackUnderflow), 32'd0);
        run_instr(1'b1, 2'b11, 16'h0000, 0, 0);
        chk("ret9_unf", 32'(stackUnderflow), 32'd1);
        chk("ret9_pc", 32'(pcOut), 32'h0002);

        // reset during EXEC with done and a call asserted
        instrReady = 1'b1;
        step();
        instrReady     = 1'b0;
        reset          = 1'b1;
        done           = 1'b1;
        redirect       = 1'b1;
        redirectKind   = 2'b10;
        redirectTarget = 16'h5555;
        step();
        done = 1'b0; redirect = 1'b0;
        do_reset_checks("rst_exec");
        reset = 1'b0;
        model_reset();
        step();
        chk_offer("post_rst2");

        // randomized instruction stream against the queue model
        for (int n = 0; n < 200; n++) begin
            logic [1:0] k;
            logic r;
            r = ($urandom_range(0, 3) != 0);
            k = 2'($urandom_range(0, 3));
            run_instr(r, k, 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
        end
        chk_offer("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
